// File: rtl/responder_pkg.sv
// ==================================================================
// responder_pkg: beep request codes, sequencer states, pulse lookup.
// Rev 1.0
// ==================================================================
`default_nettype none

package responder_pkg;

  localparam logic [1:0] BEEP_SHORT  = 2'd0;
  localparam logic [1:0] BEEP_DOUBLE = 2'd1;
  localparam logic [1:0] BEEP_TRIPLE = 2'd2;
  localparam logic [1:0] BEEP_LONG   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  function automatic logic [1:0] pulse_count(input logic [1:0] code);
    case (code)
      BEEP_DOUBLE: return 2'd2;
      BEEP_TRIPLE: return 2'd3;
      default:     return 2'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/beep_sequencer_tone.sv
// ==================================================================
// tone_gen: registered 50%-duty square wave, phase restarts on clr.
// Rev 1.0
// ==================================================================
`default_nettype none

module tone_gen #(
  parameter int TONE_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int TW = $clog2(TONE_DIV);

  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = '0;
    if (en && !clr) begin
      w_cnt_nxt = (r_cnt == TW'(TONE_DIV - 1)) ? '0 : r_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      tone  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      tone  <= en && (w_cnt_nxt < TW'(TONE_DIV / 2));
    end
  end

endmodule

`default_nettype wire

// File: rtl/beep_sequencer.sv
// ==================================================================
// beep_sequencer: accepts coded beep requests, plays timed on/gap tones.
// Rev 1.0
// ==================================================================
`default_nettype none

module beep_sequencer #(
  parameter int TONE_DIV = 1_000_000,
  parameter int MS_DIV   = 100_000,
  parameter int SHORT_MS = 100,
  parameter int GAP_MS   = 100,
  parameter int LONG_MS  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_code,
  output logic       req_ready,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       beep
);

  import responder_pkg::*;

  localparam int MAX_MS_A = (LONG_MS > SHORT_MS) ? LONG_MS : SHORT_MS;
  localparam int MAX_MS   = (MAX_MS_A > GAP_MS) ? MAX_MS_A : GAP_MS;
  localparam int MW       = $clog2(MAX_MS + 1);
  localparam int PW       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [1:0]      r_pulses;
  logic [MW-1:0]   r_dur;
  logic [PW-1:0]   r_presc;
  logic [MW-1:0]   r_ms;
  logic            w_accept;
  logic            w_ms_tick;
  logic            w_on_end;
  logic            w_gap_end;
  logic            w_done_nxt;
  logic            w_tone_en;
  logic            w_tone_clr;

  assign req_ready = (r_state == S_IDLE) && !abort;
  assign w_accept  = req_valid && req_ready;
  assign w_ms_tick = (r_presc == PW'(MS_DIV - 1));
  assign w_on_end  = (r_state == S_ON)  && w_ms_tick && (r_ms == r_dur - MW'(1));
  assign w_gap_end = (r_state == S_GAP) && w_ms_tick && (r_ms == MW'(GAP_MS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = S_ON;
        S_ON: begin
          if (w_on_end) begin
            if (r_pulses > 2'd1) begin
              w_state_nxt = S_GAP;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        S_GAP:   if (w_gap_end) w_state_nxt = S_ON;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pulses <= '0;
      r_dur    <= '0;
      r_presc  <= '0;
      r_ms     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      done    <= w_done_nxt;

      if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) begin
        r_presc <= '0;
        r_ms    <= '0;
      end else if (w_ms_tick) begin
        r_presc <= '0;
        r_ms    <= r_ms + MW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_accept) begin
        r_pulses <= pulse_count(req_code);
        r_dur    <= (req_code == BEEP_LONG) ? MW'(LONG_MS) : MW'(SHORT_MS);
      end else if ((r_state == S_ON) && (w_state_nxt == S_GAP)) begin
        r_pulses <= r_pulses - 2'd1;
      end
    end
  end

  // Tone is driven from the upcoming state so the registered beep lines up with r_state.
  assign w_tone_en  = (w_state_nxt == S_ON);
  assign w_tone_clr = w_tone_en && (r_state != S_ON);

  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tone_en),
    .clr  (w_tone_clr),
    .tone (beep)
  );

endmodule

`default_nettype wire

// File: tb/tb_beep_sequencer.sv
// ==================================================================
// tb_beep_sequencer: table-driven scoreboard bench for beep_sequencer.
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_beep_sequencer;

  localparam int TD = 10;
  localparam int MD = 4;
  localparam int SM = 3;
  localparam int GM = 2;
  localparam int LM = 8;

  typedef struct packed {
    logic beep;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    int code;
    int abort_at;
    bit intrude;
    int exp_busy;
    int exp_high;
    int exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_code;
  logic       req_ready;
  logic       abort;
  logic       busy;
  logic       done;
  logic       beep;

  exp_t q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  beep_sequencer #(
    .TONE_DIV(TD),
    .MS_DIV  (MD),
    .SHORT_MS(SM),
    .GAP_MS  (GM),
    .LONG_MS (LM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_code (req_code),
    .req_ready(req_ready),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .beep     (beep)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {beep,busy,done} per cycle, starting with the cycle after accept.
  task automatic push_pattern(input int code, input int abort_at, input bit tail);
    exp_t tmp[$];
    int   n;
    int   dur;
    n   = (code == 1) ? 2 : (code == 2) ? 3 : 1;
    dur = (code == 3) ? LM : SM;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < dur * MD; c++) tmp.push_back(exp_t'{((c % TD) < TD / 2), 1'b1, 1'b0});
      if (p < n - 1)
        for (int g = 0; g < GM * MD; g++) tmp.push_back(exp_t'{1'b0, 1'b1, 1'b0});
    end
    if (abort_at >= 0) begin
      while (tmp.size() > abort_at + 1) void'(tmp.pop_back());
      tmp.push_back(exp_t'{1'b0, 1'b0, 1'b0});
    end else if (tail) begin
      tmp.push_back(exp_t'{1'b0, 1'b0, 1'b1});
      tmp.push_back(exp_t'{1'b0, 1'b0, 1'b0});
    end
    foreach (tmp[i]) q.push_back(tmp[i]);
  endtask

  task automatic run_stream(input int abort_at, input bit intrude, input int hold_until,
                            input int code, input string tag,
                            output int bs, output int hi, output int dn);
    int   k;
    exp_t e;
    bit   in_win;
    k  = 0;
    bs = 0;
    hi = 0;
    dn = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("%s out[%0d]", tag, k), {29'd0, beep, busy, done}, {29'd0, e});
      bs += int'(busy);
      hi += int'(beep);
      dn += int'(done);
      in_win = intrude && (k >= 1) && (k <= 5);
      if (in_win) check($sformatf("%s ready_busy[%0d]", tag, k), {31'd0, req_ready}, 32'd0);
      if (hold_until > 0 && k == hold_until - 1)
        check($sformatf("%s ready_at_done", tag), {31'd0, req_ready}, 32'd1);
      abort     = (k == abort_at);
      req_valid = (k < hold_until) || in_win;
      req_code  = in_win ? 2'd2 : 2'(code);
      step();
      k++;
    end
    abort     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready && !busy) ok = 1'b1;
      else step();
    end
    check("wait_idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bs, hi, dn;

    vecs[0] = '{0, -1, 1'b0, 12,  7, 1};
    vecs[1] = '{1, -1, 1'b0, 32, 14, 1};
    vecs[2] = '{2, -1, 1'b0, 52, 21, 1};
    vecs[3] = '{3, -1, 1'b0, 32, 17, 1};
    vecs[4] = '{0, -1, 1'b1, 12,  7, 1};
    vecs[5] = '{2, 15, 1'b0, 16,  7, 0};

    rst       = 1'b1;
    req_valid = 1'b0;
    abort     = 1'b0;
    req_code  = 2'd0;
    step();
    check("reset outputs", {29'd0, beep, busy, done}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("reset ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      wait_idle();
      req_valid = 1'b1;
      req_code  = 2'(vecs[i].code);
      push_pattern(vecs[i].code, vecs[i].abort_at, 1'b1);
      step();
      run_stream(vecs[i].abort_at, vecs[i].intrude, 0, vecs[i].code,
                 $sformatf("vec%0d", i), bs, hi, dn);
      check($sformatf("vec%0d busy_cycles", i), bs, vecs[i].exp_busy);
      check($sformatf("vec%0d beep_high", i),   hi, vecs[i].exp_high);
      check($sformatf("vec%0d done_pulses", i), dn, vecs[i].exp_done);
    end

    // req_valid held through done: back-to-back accept in the done cycle
    wait_idle();
    req_valid = 1'b1;
    req_code  = 2'd0;
    push_pattern(0, -1, 1'b0);
    q.push_back(exp_t'{1'b0, 1'b0, 1'b1});
    push_pattern(0, -1, 1'b1);
    step();
    run_stream(-1, 1'b0, 13, 0, "held", bs, hi, dn);
    check("held busy_cycles", bs, 24);
    check("held done_pulses", dn, 2);

    // abort and req_valid together in IDLE
    wait_idle();
    abort     = 1'b1;
    req_valid = 1'b1;
    req_code  = 2'd1;
    #1;
    check("abort_idle ready", {31'd0, req_ready}, 32'd0);
    step();
    abort     = 1'b0;
    req_valid = 1'b0;
    check("abort_idle no_accept", {29'd0, beep, busy, done}, 32'd0);
    step();
    check("abort_idle still_idle", {29'd0, beep, busy, done}, 32'd0);

    // asynchronous reset mid-pattern
    wait_idle();
    req_valid = 1'b1;
    req_code  = 2'd3;
    step();
    req_valid = 1'b0;
    check("midrst first_beep", {30'd0, beep, busy}, 32'd3);
    repeat (5) step();
    check("midrst pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst outputs", {29'd0, beep, busy, done}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("midrst ready", {31'd0, req_ready}, 32'd1);
    step();
    check("midrst idle", {29'd0, beep, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
